alu_seq_core: RTL
=================

// Module: alu_seq_core
// PURPOSE
//  Parametrised, handshaked successor to the 32-bit combinational ALU: RV32I integer ops plus
//  an iterative shift-add multiply. Operands/op enter via valid/ready, result leaves via
//  valid/ready. One op in flight. Drives the same VIO/ILA debug wrapper in place of ALU32.
// PARAMETERS
//  WIDTH     32  operand/result width in bits; power of two, >=8
//  OPWIDTH   4   op-code width; codes >=11 are illegal
//  SHAMT_W   $clog2(WIDTH) (localparam)  shift-amount bits taken from in2[SHAMT_W-1:0]
// PORTS
//  clk        in   1        single clock, all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        in1/in2/op valid this cycle
//  in_ready   out  1        core can accept; transfer when in_valid & in_ready
//  in1        in   WIDTH    operand A
//  in2        in   WIDTH    operand B / shift amount
//  op         in   OPWIDTH  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 MUL
//  out_valid  out  1        result valid; held until out_ready
//  out_ready  in   1        consumer takes result when out_valid & out_ready
//  out        out  WIDTH    result
//  zero       out  1        out == 0
//  ovf        out  1        signed overflow, ADD/SUB only; 0 otherwise
//  err        out  1        op code illegal; out forced 0
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1 after reset edge; out_valid=0, out=0, zero=0, ovf=0, err=0;
//    multiply counter/accumulator cleared. Reset mid-MUL or in DONE aborts; result dropped.
//  - FSM: IDLE -> DONE on accept of non-MUL op; IDLE -> MUL on accept of op 10;
//    MUL -> DONE when bit counter reaches 0; DONE -> IDLE on out_valid & out_ready.
//  - in_ready = (state==IDLE), combinational from state only. out_valid = (state==DONE).
//  - Inputs sampled only on the accept edge; later changes to in1/in2/op ignored.
//  - Non-MUL latency: accept at edge N, out_valid high after edge N (next cycle), 1 cycle.
//  - MUL: low WIDTH bits of in1*in2 (signedness irrelevant). Accept edge loads acc=0,
//    mcand=in1, mplier=in2, cnt=WIDTH. Each MUL cycle: if mplier[0] acc+=mcand;
//    mcand<<=1; mplier>>=1; cnt-=1. out_valid after WIDTH+1 edges from accept.
//  - Back-to-back: from DONE with out_ready=1, next accept earliest one cycle later
//    (IDLE cycle); throughput 1 op / 2 cycles for single-cycle ops.
//  - out/zero/ovf/err registered, stable whole DONE period; out_ready while not
//    out_valid has no effect.
//  - Arithmetic: ADD/SUB wrap modulo 2^WIDTH; ovf = operand signs equal (B inverted for SUB)
//    and result sign differs. SLT signed, SLTU unsigned, result 0 or 1 zero-extended.
//  - Shifts use in2[SHAMT_W-1:0] only; SRA sign-fills; shift by 0 returns in1.
//  - Illegal op (11..15): single-cycle path, out=0, err=1, zero=1.
// TESTING
//  1 Reset then ADD 0x7FFFFFFF+1 -> 1 cycle: out=0x80000000, ovf=1, zero=0, err=0.
//  2 SUB 5-5 -> out=0, zero=1, ovf=0; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
//  3 SRA 0x80000000 by in2=0x24 (amt 4) -> 0xF8000000; SRL -> 0x08000000; SLL 1 by 31 -> 0x80000000.
//  4 MUL 0x0001_0003 * 0x0000_0005 -> out_valid exactly 33 edges after accept, out=0x0005_000F;
//    in_ready=0 throughout; MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
//  5 Backpressure: hold out_ready=0 for 10 cycles after XOR result -> out_valid, out stable,
//    in_ready=0; toggle in1 meanwhile -> out unchanged; release -> IDLE next cycle.
//  6 Assert rst at MUL cycle 12 -> next cycle out_valid=0, in_ready=1; op=13 -> err=1, out=0.

Source files
------------

// File: rtl/alu_seq_core.sv
// alu_seq_core
//   Handshaked RV32I-style ALU with an iterative shift-add multiplier.
//   One operation in flight: accept on in_valid & in_ready, present the
//   result on out_valid until out_ready takes it.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   operand handshake (in_ready high only in IDLE)
//   in1, in2, op         operands and op code (0..10 legal)
//   out_valid, out_ready result handshake (out_valid high only in DONE)
//   out, zero, ovf, err  registered result and flags
module alu_seq_core #(
  parameter int WIDTH   = 32,
  parameter int OPWIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [OPWIDTH-1:0] op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               zero,
  output logic               ovf,
  output logic               err
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;

  localparam logic [OPWIDTH-1:0] OP_ADD  = OPWIDTH'(0);
  localparam logic [OPWIDTH-1:0] OP_SUB  = OPWIDTH'(1);
  localparam logic [OPWIDTH-1:0] OP_SLL  = OPWIDTH'(2);
  localparam logic [OPWIDTH-1:0] OP_SLT  = OPWIDTH'(3);
  localparam logic [OPWIDTH-1:0] OP_SLTU = OPWIDTH'(4);
  localparam logic [OPWIDTH-1:0] OP_XOR  = OPWIDTH'(5);
  localparam logic [OPWIDTH-1:0] OP_SRL  = OPWIDTH'(6);
  localparam logic [OPWIDTH-1:0] OP_SRA  = OPWIDTH'(7);
  localparam logic [OPWIDTH-1:0] OP_OR   = OPWIDTH'(8);
  localparam logic [OPWIDTH-1:0] OP_AND  = OPWIDTH'(9);
  localparam logic [OPWIDTH-1:0] OP_MUL  = OPWIDTH'(10);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state, state_next;

  logic [WIDTH-1:0]   acc, mcand, mplier;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   out_r;
  logic               zero_r, ovf_r, err_r;

  logic               accept;
  logic [WIDTH-1:0]   sum, diff;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf, alu_err;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (op == OP_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign sum    = in1 + in2;
  assign diff   = in1 - in2;
  assign shamt  = in2[SHAMT_W-1:0];

  // Single-cycle ALU evaluated on the live inputs; only captured on accept
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SLL:  alu_res = in1 << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_XOR:  alu_res = in1 ^ in2;
      OP_SRL:  alu_res = in1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in1) >>> shamt);
      OP_OR:   alu_res = in1 | in2;
      OP_AND:  alu_res = in1 & in2;
      OP_MUL:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // Datapath: result capture and multiplier iteration. The MUL state runs
  // WIDTH shift-add steps, then spends one more cycle (cnt == 0) latching acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      out_r  <= '0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              acc    <= '0;
              mcand  <= in1;
              mplier <= in2;
              cnt    <= CNT_W'(WIDTH);
            end else begin
              out_r  <= alu_res;
              zero_r <= (alu_res == '0);
              ovf_r  <= alu_ovf;
              err_r  <= alu_err;
            end
          end
        end
        MUL: begin
          if (cnt == '0) begin
            out_r  <= acc;
            zero_r <= (acc == '0);
            ovf_r  <= 1'b0;
            err_r  <= 1'b0;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out  = out_r;
  assign zero = zero_r;
  assign ovf  = ovf_r;
  assign err  = err_r;

endmodule
